// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flip-flop FIFO.
//  FIFO_DEPTH_DEF / FIFO_BITS_DEF : default entry count and word width
//  clog2()                        : ceil(log2(value)), used to size pointers and the occupancy count
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned FIFO_BITS_DEF  = 16;

    // Returns the number of bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer counter for the flip-flop FIFO.
//  Counts 0 .. DEPTH-1 and wraps explicitly, so DEPTH need not be a power of two.
// Ports:
//  clk : clock, rising edge
//  rst : synchronous active-high reset, clears the pointer to 0
//  inc : advance the pointer by one at the next edge
//  ptr : current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc,
    output logic [clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned PW = clog2(DEPTH);

    logic [PW-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr;
        if (inc) begin
            ptr_next = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/fifo_flop_mem.sv
// Single-clock first-word-fall-through FIFO built from a register array.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky ovf/udf error outputs.
// Ports:
//  clk   : clock, rising edge
//  rst   : synchronous active-high reset; discards all data, wins over push/pop
//  Din   : write data, stored on an accepted push
//  push  : write request, one word per cycle while high
//  pop   : read request, removes the head word at the edge
//  Dout  : head-of-queue word, 0 when empty
//  full  : count == DEPTH
//  pndng : count != 0
//  ovf   : (FIFO_ERR_FLAGS_EN) sticky, set by a rejected push while full
//  udf   : (FIFO_ERR_FLAGS_EN) sticky, set by a pop while empty
module fifo_flop_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned BITS  = FIFO_BITS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] Din,
    input  logic            push,
    input  logic            pop,
    output logic [BITS-1:0] Dout,
    output logic            full,
    output logic            pndng
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic            ovf,
    output logic            udf
`endif
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push_ok;
    logic            pop_ok;

    assign pndng  = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign pop_ok = pop & pndng;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    // No bypass when empty: pop_ok is 0 there, so only the push lands.
    assign push_ok = push & (~full | pop_ok);
    assign Dout    = pndng ? mem[rd_ptr] : '0;

    fifo_ptr #(
        .DEPTH(DEPTH)
    ) u_wr_ptr (
        .clk(clk),
        .rst(rst),
        .inc(push_ok),
        .ptr(wr_ptr)
    );

    fifo_ptr #(
        .DEPTH(DEPTH)
    ) u_rd_ptr (
        .clk(clk),
        .rst(rst),
        .inc(pop_ok),
        .ptr(rd_ptr)
    );

    // Storage is not reset; stale words are hidden because Dout is gated by pndng.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= Din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push && !push_ok) ovf <= 1'b1;
            if (pop && !pndng)    udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flop_mem.sv
// Self-checking bench for fifo_flop_mem: directed scenarios followed by randomized traffic,
// all compared each cycle against a queue-based reference model.
module tb_fifo_flop_mem;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned BITS  = 16;

    logic            clk;
    logic            rst;
    logic [BITS-1:0] din;
    logic            push;
    logic            pop;
    logic [BITS-1:0] dout;
    logic            full;
    logic            pndng;
`ifdef FIFO_ERR_FLAGS_EN
    logic            ovf;
    logic            udf;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    logic [BITS-1:0] model_q[$];
    bit              ovf_m;
    bit              udf_m;

    fifo_flop_mem #(
        .DEPTH(DEPTH),
        .BITS (BITS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .Din  (din),
        .push (push),
        .pop  (pop),
        .Dout (dout),
        .full (full),
        .pndng(pndng)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .ovf  (ovf),
        .udf  (udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model by the FIFO rules, then compare.
    task automatic step(input logic r, input logic pu, input logic po, input logic [BITS-1:0] d);
        bit do_pop;
        bit do_push;
        @(negedge clk);
        rst  = r;
        push = pu;
        pop  = po;
        din  = d;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            ovf_m = 0;
            udf_m = 0;
        end else begin
            do_pop  = po && (model_q.size() > 0);
            do_push = pu && ((model_q.size() < DEPTH) || do_pop);
            if (pu && !do_push) ovf_m = 1;
            if (po && model_q.size() == 0) udf_m = 1;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
        check("count", 32'(dut.count), 32'(model_q.size()));
        check("full",  32'(full),      32'(model_q.size() == DEPTH));
        check("pndng", 32'(pndng),     32'(model_q.size() != 0));
        check("dout",  32'(dout),      (model_q.size() != 0) ? 32'(model_q[0]) : 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf",   32'(ovf),       32'(ovf_m));
        check("udf",   32'(udf),       32'(udf_m));
`endif
    endtask

    initial begin
        int unsigned push_pct;
        int unsigned pop_pct;
        n_tests = 0;
        n_fail  = 0;
        ovf_m   = 0;
        udf_m   = 0;
        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        din     = '0;

        step(1, 0, 0, '0);
        step(1, 0, 0, '0);

        // Fill 0..15, then overflow attempt with 99.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, BITS'(i));
        check("fill_full", 32'(full), 32'd1);
        step(0, 1, 0, BITS'(99));
        check("ovf_count", 32'(dut.count), 32'(DEPTH));

        // Drain; model checks Dout order 0..15 and that 99 never appears.
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_head", 32'(dout), 32'(i));
            step(0, 0, 1, '0);
        end
        check("drain_dout", 32'(dout), 32'd0);

        // Underflow, then push+pop on empty (no bypass).
        step(0, 0, 1, '0);
        step(0, 1, 1, BITS'(16'h00aa));
        check("empty_pp_count", 32'(dut.count), 32'd1);
        step(0, 0, 1, '0);

        // Hold count at 5 with concurrent push+pop across wrap-around.
        for (int i = 0; i < 5; i++) step(0, 1, 0, BITS'(100 + i));
        for (int i = 0; i < 20; i++) step(0, 1, 1, BITS'(105 + i));
        check("hold5", 32'(dut.count), 32'd5);

        // Fill and push+pop while full.
        for (int i = 0; i < 11; i++) step(0, 1, 0, BITS'(200 + i));
        step(0, 1, 1, BITS'(300));
        check("full_pp", 32'(dut.count), 32'(DEPTH));

        // Reset mid-run with push held high.
        step(1, 0, 0, '0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, BITS'(400 + i));
        step(1, 1, 0, BITS'(16'hbeef));
        check("rst_mid_count", 32'(dut.count), 32'd0);
        check("rst_mid_dout", 32'(dout), 32'd0);

        // Randomized traffic with phase-varying bias to visit empty and full.
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       begin push_pct = 80; pop_pct = 30; end
                1:       begin push_pct = 30; pop_pct = 80; end
                default: begin push_pct = 60; pop_pct = 60; end
            endcase
            for (int c = 0; c < 150; c++) begin
                step(($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 99) < push_pct),
                     ($urandom_range(0, 99) < pop_pct),
                     BITS'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
